// File: rtl/main_memory_responder.sv
// Responder for the L3 <-> main-memory request/ready handshake: services block
// reads/writes against an internal array after a fixed latency and pulses ready.
module main_memory_responder #(
  parameter int unsigned MAIN_MEMORY_ADDRESS_WIDTH = 32,
  parameter int unsigned MAIN_MEMORY_DATA_WIDTH    = 256,
  parameter int unsigned MEM_DEPTH_LOG2            = 10,
  parameter int unsigned ACCESS_LATENCY            = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 main_memory_read_request,
  input  logic                                 main_memory_write_request,
  input  logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] main_memory_address,
  input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]    main_memory_write_data,
  output logic [MAIN_MEMORY_DATA_WIDTH-1:0]    main_memory_read_data,
  output logic                                 main_memory_ready,
  output logic                                 main_memory_busy,
  output logic                                 protocol_error
);

  localparam int unsigned DW    = MAIN_MEMORY_DATA_WIDTH;
  localparam int unsigned IW    = MEM_DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << IW;
  localparam int unsigned CW    = 8;
  localparam logic [CW-1:0] LAT_M1 = CW'(ACCESS_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_BUSY         = 2'd1,
    S_RESPOND      = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic          write;
    logic [IW-1:0] index;
    logic [DW-1:0] data;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          perr_q, perr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          any_req;
  logic          mem_we;

  logic [DW-1:0] mem [DEPTH];

  assign any_req = main_memory_read_request | main_memory_write_request;
  assign mem_we  = (state_q == S_RESPOND) && req_q.write;

  // Next-state, capture and registered-output decode
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    perr_d  = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          req_d.write = main_memory_write_request;
          req_d.index = main_memory_address[IW-1:0];
          req_d.data  = main_memory_write_data;
          cnt_d       = LAT_M1;
          perr_d      = main_memory_read_request & main_memory_write_request;
          state_d     = (ACCESS_LATENCY <= 1) ? S_RESPOND : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        state_d = any_req ? S_WAIT_RELEASE : S_IDLE;
      end
      S_WAIT_RELEASE: begin
        if (!any_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_RESPOND);
    busy_d  = (state_d != S_IDLE);
    // Read result is loaded on the edge that enters RESPOND and held afterwards
    if ((state_d == S_RESPOND) && (state_q != S_RESPOND) && !req_d.write)
      rdata_d = mem[req_d.index];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
      rdata_q <= rdata_d;
    end
  end

  // Write commits on the edge leaving RESPOND; an aborting reset forces IDLE first
  always_ff @(posedge clk) begin
    if (mem_we) mem[req_q.index] <= req_q.data;
  end

  assign main_memory_read_data = rdata_q;
  assign main_memory_ready     = ready_q;
  assign main_memory_busy      = busy_q;
  assign protocol_error        = perr_q;

endmodule
